// File: rtl/jtdsp16_sirx_if.sv
// CPU-side bus of the DSP16 serial input receiver: configuration load,
// data read strobe, and received word with its status flags.
interface jtdsp16_sirx_if;
    logic        cfg_ld;
    logic [1:0]  cfg_din;
    logic        sdx_rd;
    logic [15:0] sdx_dout;
    logic        ibf;
    logic        ovf;

    modport master (
        output cfg_ld, cfg_din, sdx_rd,
        input  sdx_dout, ibf, ovf
    );

    modport slave (
        input  cfg_ld, cfg_din, sdx_rd,
        output sdx_dout, ibf, ovf
    );
endinterface

// File: rtl/jtdsp16_sirx.sv
// DSP16 serial input receiver: synchronises di/ick/ild, shifts 8/16-bit frames.
// Define JTDSP16_SIRX_OVF_EN to build the sticky overrun flag; otherwise ovf is tied 0.
module jtdsp16_sirx (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           di,
    input  logic           ick,
    input  logic           ild,
    jtdsp16_sirx_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, next_state;
    logic [1:0]  di_sync;
    logic [2:0]  ick_sync, ild_sync;
    logic        ick_rise, ild_fall, di_bit;
    logic        ilen, lsbf, frm_ilen, frm_lsbf;
    logic [3:0]  cnt, last_idx;
    logic [15:0] shreg, shreg_next, dout;
    logic        start, capture, last, done, ibf, rd_q;

    // ild flops reset high so reset release never looks like a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            di_sync  <= 2'b00;
            ick_sync <= 3'b000;
            ild_sync <= 3'b111;
        end else begin
            di_sync  <= {di_sync[0], di};
            ick_sync <= {ick_sync[1:0], ick};
            ild_sync <= {ild_sync[1:0], ild};
        end
    end

    assign ick_rise = ick_sync[1] & ~ick_sync[2];
    assign ild_fall = ~ild_sync[1] & ild_sync[2];
    assign di_bit   = di_sync[1];
    assign rd_q     = cen & bus.sdx_rd;
    assign last_idx = frm_ilen ? 4'd7 : 4'd15;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        capture    = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (ild_fall) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (ild_fall) begin
                    start = 1'b1;
                end else if (ick_rise) begin
                    capture = 1'b1;
                    if (cnt == last_idx) begin
                        last       = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // LSB-first entry point sits at bit N-1, so 8-bit words stay in [7:0]
    always_comb begin
        shreg_next = {shreg[14:0], di_bit};
        if (frm_lsbf) begin
            if (frm_ilen) shreg_next = {8'h00, di_bit, shreg[7:1]};
            else          shreg_next = {di_bit, shreg[15:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            shreg    <= 16'd0;
            frm_ilen <= 1'b0;
            frm_lsbf <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last;
            if (start) begin
                cnt      <= 4'd0;
                shreg    <= 16'd0;
                frm_ilen <= ilen;
                frm_lsbf <= lsbf;
            end else if (capture) begin
                cnt   <= cnt + 4'd1;
                shreg <= shreg_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ilen <= 1'b0;
            lsbf <= 1'b0;
        end else if (cen && bus.cfg_ld) begin
            ilen <= bus.cfg_din[0];
            lsbf <= bus.cfg_din[1];
        end
    end

    // a completion wins over a simultaneous read, so ibf stays set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 16'd0;
            ibf  <= 1'b0;
        end else if (done) begin
            dout <= shreg;
            ibf  <= 1'b1;
        end else if (rd_q) begin
            ibf <= 1'b0;
        end
    end

`ifdef JTDSP16_SIRX_OVF_EN
    logic ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ovf <= 1'b0;
        else if (done) ovf <= rd_q ? 1'b0 : (ovf | ibf);
        else if (rd_q) ovf <= 1'b0;
    end

    assign bus.ovf = ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.sdx_dout = dout;
    assign bus.ibf      = ibf;

endmodule

// File: tb/tb_jtdsp16_sirx.sv
// Scoreboard bench for jtdsp16_sirx: frames push expected words, a monitor
// pops them whenever the receiver delivers a new word.
module tb_jtdsp16_sirx;

    typedef struct {
        logic [15:0] dout;
        logic        ibf;
        logic        ovf;
    } exp_t;

`ifdef JTDSP16_SIRX_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    logic di  = 1'b0;
    logic ick = 1'b0;
    logic ild = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    jtdsp16_sirx_if bus ();

    jtdsp16_sirx dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .di  (di),
        .ick (ick),
        .ild (ild),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    // monitor: a delivery is ibf rising, or a new word while ibf is held
    logic        ibf_q  = 1'b0;
    logic [15:0] dout_q = 16'd0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.ibf && (!ibf_q || bus.sdx_dout != dout_q)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL delivery: unexpected word %h ibf=%b ovf=%b, required no delivery",
                         bus.sdx_dout, bus.ibf, bus.ovf);
            end else begin
                e = sb.pop_front();
                if ({bus.sdx_dout, bus.ibf, bus.ovf} !== {e.dout, e.ibf, e.ovf}) begin
                    errors++;
                    $display("[TB] FAIL delivery: got dout=%h ibf=%b ovf=%b, required dout=%h ibf=%b ovf=%b",
                             bus.sdx_dout, bus.ibf, bus.ovf, e.dout, e.ibf, e.ovf);
                end
            end
        end
        ibf_q  = bus.ibf;
        dout_q = bus.sdx_dout;
    end

    task automatic expectWord(input logic [15:0] w, input logic f, input logic o);
        exp_t e;
        e.dout = w;
        e.ibf  = f;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] w, input logic f, input logic o);
        checks++;
        if ({bus.sdx_dout, bus.ibf, bus.ovf} !== {w, f, o}) begin
            errors++;
            $display("[TB] FAIL %s: got dout=%h ibf=%b ovf=%b, required dout=%h ibf=%b ovf=%b",
                     name, bus.sdx_dout, bus.ibf, bus.ovf, w, f, o);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d expected words never delivered, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic startFrame();
        ild = 1'b0;
        repeat (4) @(negedge clk);
        ild = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // the read strobe lands in the completion clk: edge captured 3 clk in, word loads the next
    task automatic sendBit(input logic b, input bit rd_at_done);
        di = b;
        repeat (2) @(negedge clk);
        ick = 1'b1;
        if (rd_at_done) begin
            repeat (3) @(negedge clk);
            bus.sdx_rd = 1'b1;
            @(negedge clk);
            bus.sdx_rd = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
        ick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic doCfg(input logic [1:0] din, input logic c);
        bus.cfg_din = din;
        bus.cfg_ld  = 1'b1;
        cen         = c;
        @(negedge clk);
        bus.cfg_ld  = 1'b0;
        cen         = 1'b1;
    endtask

    task automatic doRead(input logic c);
        bus.sdx_rd = 1'b1;
        cen        = c;
        @(negedge clk);
        bus.sdx_rd = 1'b0;
        cen        = 1'b1;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit lsb_first,
                                 input bit rd_at_end, input bit cfg_mid);
        logic [15:0] w;
        int          idx;
        w = word;
        startFrame();
        for (int k = 0; k < nbits; k++) begin
            idx = lsb_first ? k : nbits - 1 - k;
            if (cfg_mid && k == 3) doCfg(2'b00, 1'b1);
            sendBit(w[idx], rd_at_end && (k == nbits - 1));
        end
    endtask

    initial begin
        bus.cfg_ld  = 1'b0;
        bus.cfg_din = 2'b00;
        bus.sdx_rd  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 16'h0000, 1'b0, 1'b0);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);

        expectWord(16'hA5C3, 1'b1, 1'b0);
        applyStimulus(16'hA5C3, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("msb16");
        doRead(1'b1);
        checkOutput("read_a5c3", 16'hA5C3, 1'b0, 1'b0);

        doCfg(2'b11, 1'b0);
        expectWord(16'h1234, 1'b1, 1'b0);
        applyStimulus(16'h1234, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("cfg_nocen");
        doRead(1'b0);
        checkOutput("read_nocen", 16'h1234, 1'b1, 1'b0);
        expectWord(16'h5678, 1'b1, OVF_ON);
        applyStimulus(16'h5678, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("overrun");
        doRead(1'b1);
        checkOutput("read_overrun", 16'h5678, 1'b0, 1'b0);

        doCfg(2'b11, 1'b1);
        expectWord(16'h000D, 1'b1, 1'b0);
        applyStimulus(16'h000D, 8, 1'b1, 1'b0, 1'b1);
        waitDrain("lsb8");
        doRead(1'b1);
        checkOutput("read_lsb8", 16'h000D, 1'b0, 1'b0);

        expectWord(16'hBEEF, 1'b1, 1'b0);
        applyStimulus(16'hBEEF, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("cfg_after_frame");
        expectWord(16'hC0DE, 1'b1, 1'b0);
        applyStimulus(16'hC0DE, 16, 1'b0, 1'b1, 1'b0);
        waitDrain("coincident");
        checkOutput("coincident_hold", 16'hC0DE, 1'b1, 1'b0);
        doRead(1'b1);

        startFrame();
        for (int k = 0; k < 5; k++) sendBit(1'b1, 1'b0);
        expectWord(16'h00FF, 1'b1, 1'b0);
        applyStimulus(16'h00FF, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("restart");
        checkOutput("restart_hold", 16'h00FF, 1'b1, 1'b0);

        startFrame();
        for (int k = 0; k < 10; k++) sendBit(1'b1, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 6; k++) sendBit(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("reset_midframe", 16'h0000, 1'b0, 1'b0);

        expectWord(16'h5A5A, 1'b1, 1'b0);
        applyStimulus(16'h5A5A, 16, 1'b0, 1'b0, 1'b0);
        waitDrain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
